// File: rtl/arm_regfile.sv
// ============================================================================
//  Module   : arm_regfile
//  Purpose  : ARM architectural register file (R0-R14 stored, R15 = PC+8
//             supplied externally) with shifter shift-amount selection.
//  Options  : ARM_REGFILE_BYPASS_EN - same-cycle write-to-read forwarding.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arm_regfile #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         we3,
  input  logic [3:0]   wa3,
  input  logic [N-1:0] wd3,
  input  logic [3:0]   ra1,
  input  logic [3:0]   ra2,
  input  logic [3:0]   ra3,
  input  logic [N-1:0] r15,
  input  logic [4:0]   shamt_imm,
  input  logic         sh_reg,
  output logic [N-1:0] rd1,
  output logic [N-1:0] rd2,
  output logic [N-1:0] rd3,
  output logic [4:0]   shamt5,
  output logic         shamt_big
);

  localparam logic [3:0] c_pc_addr = 4'd15;
  localparam int         c_nregs   = 15;
  localparam int         c_nports  = 3;

  logic [N-1:0] r_regs [0:c_nregs-1];
  logic [N-1:0] w_view [0:15];
  logic [3:0]   w_ra   [0:c_nports-1];
  logic [N-1:0] w_rd   [0:c_nports-1];
  logic         w_wr_en;

  // Writes to the PC address are dropped; fetch owns the PC.
  assign w_wr_en = reset_n && we3 && (wa3 != c_pc_addr);

  always_ff @(posedge clk) begin
    for (int i = 0; i < c_nregs; i++) begin
      if (!reset_n) begin
        r_regs[i] <= '0;
      end else if (w_wr_en && (wa3 == 4'(i))) begin
        r_regs[i] <= wd3;
      end
    end
  end

  // Full 16-entry read view with R15 spliced in from the fetch stage.
  for (genvar gi = 0; gi < c_nregs; gi++) begin : g_view
    assign w_view[gi] = r_regs[gi];
  end
  assign w_view[15] = r15;

  assign w_ra[0] = ra1;
  assign w_ra[1] = ra2;
  assign w_ra[2] = ra3;

  for (genvar gp = 0; gp < c_nports; gp++) begin : g_port
`ifdef ARM_REGFILE_BYPASS_EN
    assign w_rd[gp] = (w_wr_en && (w_ra[gp] == wa3)) ? wd3 : w_view[w_ra[gp]];
`else
    assign w_rd[gp] = w_view[w_ra[gp]];
`endif
  end

  assign rd1 = w_rd[0];
  assign rd2 = w_rd[1];
  assign rd3 = w_rd[2];

  // Register shifts use Rs[7:0]; bits above 7 are architecturally ignored.
  assign shamt5    = sh_reg ? rd3[4:0] : shamt_imm;
  assign shamt_big = sh_reg && (|rd3[7:5]);

endmodule

`default_nettype wire

// File: tb/tb_arm_regfile.sv
// ============================================================================
//  Module   : tb_arm_regfile
//  Purpose  : Directed self-checking bench for arm_regfile.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arm_regfile;

  localparam int N = 32;
`ifdef ARM_REGFILE_BYPASS_EN
  localparam bit c_byp = 1'b1;
`else
  localparam bit c_byp = 1'b0;
`endif

  logic         clk;
  logic         reset_n;
  logic         we3;
  logic [3:0]   wa3;
  logic [N-1:0] wd3;
  logic [3:0]   ra1, ra2, ra3;
  logic [N-1:0] r15;
  logic [4:0]   shamt_imm;
  logic         sh_reg;
  logic [N-1:0] rd1, rd2, rd3;
  logic [4:0]   shamt5;
  logic         shamt_big;

  int vectors;
  int miscompares;

  arm_regfile #(.N(N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .we3       (we3),
    .wa3       (wa3),
    .wd3       (wd3),
    .ra1       (ra1),
    .ra2       (ra2),
    .ra3       (ra3),
    .r15       (r15),
    .shamt_imm (shamt_imm),
    .sh_reg    (sh_reg),
    .rd1       (rd1),
    .rd2       (rd2),
    .rd3       (rd3),
    .shamt5    (shamt5),
    .shamt_big (shamt_big)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow a settle delay.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [N-1:0] d);
    we3 = 1'b1; wa3 = a; wd3 = d;
    tick();
    we3 = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset_n = 1'b0; we3 = 1'b0; wa3 = '0; wd3 = '0;
    ra1 = '0; ra2 = '0; ra3 = '0; r15 = 32'h0000_0048;
    shamt_imm = '0; sh_reg = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;

    // Reset state
    ra1 = 4'd0; ra2 = 4'd15; ra3 = 4'd14; #1;
    check("rst_rd1_r0", rd1, 32'h0);
    check("rst_rd2_r15", rd2, 32'h48);
    check("rst_rd3_r14", rd3, 32'h0);
    check("rst_shamt5", {27'd0, shamt5}, 32'd0);
    check("rst_big", {31'd0, shamt_big}, 32'd0);

    // Reset wipes a stored value and wins over a simultaneous write
    write_reg(4'd3, 32'hDEAD_BEEF);
    ra1 = 4'd3; #1;
    check("pre_rst_r3", rd1, 32'hDEAD_BEEF);
    reset_n = 1'b0; we3 = 1'b1; wa3 = 4'd5; wd3 = 32'h11; ra2 = 4'd5; #1;
    check("rst_no_fwd_r3", rd1, 32'hDEAD_BEEF);
    check("rst_no_fwd_r5", rd2, 32'h0);
    tick();
    reset_n = 1'b1; we3 = 1'b0; #1;
    check("rst_clr_r3", rd1, 32'h0);
    check("rst_drop_r5", rd2, 32'h0);

    // Write every general register, then read through all three ports
    for (int i = 0; i < 15; i++) write_reg(4'(i), 32'h100 + 32'(i));
    for (int i = 0; i < 15; i++) begin
      ra1 = 4'(i); ra2 = 4'(i); ra3 = 4'(i); #1;
      check($sformatf("wr_rd1_r%0d", i), rd1, 32'h100 + 32'(i));
      check($sformatf("wr_rd2_r%0d", i), rd2, 32'h100 + 32'(i));
      check($sformatf("wr_rd3_r%0d", i), rd3, 32'h100 + 32'(i));
    end
    ra2 = 4'd15; #1;
    check("rd2_pc", rd2, 32'h48);

    // Writes to address 15 are discarded
    write_reg(4'd15, 32'hFFFF_FFFF);
    ra1 = 4'd15; #1;
    check("r15_drop", rd1, 32'h48);
    r15 = 32'h0000_1234; #1;
    check("r15_follow", rd1, 32'h1234);
    for (int i = 0; i < 15; i++) begin
      ra1 = 4'(i); #1;
      check($sformatf("r15_keep_r%0d", i), rd1, 32'h100 + 32'(i));
    end

    // Shift-amount selection
    write_reg(4'd7, 32'h25);
    sh_reg = 1'b1; ra3 = 4'd7; #1;
    check("sh_25_amt", {27'd0, shamt5}, 32'd5);
    check("sh_25_big", {31'd0, shamt_big}, 32'd1);
    write_reg(4'd7, 32'h1F); #1;
    check("sh_1f_amt", {27'd0, shamt5}, 32'd31);
    check("sh_1f_big", {31'd0, shamt_big}, 32'd0);
    write_reg(4'd7, 32'hFFFF_FF00); #1;
    check("sh_hi_amt", {27'd0, shamt5}, 32'd0);
    check("sh_hi_big", {31'd0, shamt_big}, 32'd0);
    ra3 = 4'd15; r15 = 32'h0000_0048; #1;
    check("sh_pc_amt", {27'd0, shamt5}, 32'd8);
    check("sh_pc_big", {31'd0, shamt_big}, 32'd1);
    sh_reg = 1'b0; shamt_imm = 5'd12; ra3 = 4'd7; #1;
    check("sh_imm_amt", {27'd0, shamt5}, 32'd12);
    check("sh_imm_big", {31'd0, shamt_big}, 32'd0);

    // Same-cycle read of the register being written
    write_reg(4'd2, 32'hA);
    sh_reg = 1'b1;
    we3 = 1'b1; wa3 = 4'd2; wd3 = 32'hB; ra1 = 4'd2; ra2 = 4'd2; ra3 = 4'd2; #1;
    check("haz_rd1", rd1, c_byp ? 32'hB : 32'hA);
    check("haz_rd2", rd2, c_byp ? 32'hB : 32'hA);
    check("haz_rd3", rd3, c_byp ? 32'hB : 32'hA);
    check("haz_shamt5", {27'd0, shamt5}, c_byp ? 32'd11 : 32'd10);
    tick();
    we3 = 1'b0; #1;
    check("haz_nx_rd1", rd1, 32'hB);
    check("haz_nx_rd2", rd2, 32'hB);
    check("haz_nx_rd3", rd3, 32'hB);

    // Port independence
    ra1 = 4'd1; ra2 = 4'd1; ra3 = 4'd14; #1;
    check("ind_rd1", rd1, 32'h101);
    check("ind_rd2", rd2, 32'h101);
    check("ind_rd3", rd3, 32'h10E);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
